csr_rmw_unit: RTL

Multi-cycle Zicsr execution unit for the kianv SoC core. Accepts a decoded CSR instruction over a valid/ready handshake, performs the read-modify-write sequence against the CSR file over a request/acknowledge bus, and returns the old CSR value for rd. It generalises the combinational CSR decode to a parametrised datapath width with a bus timeout and optional access checking. It sits between the core's execute stage and the CSR file.

---
 rtl/csr_unit_pkg.sv | 68 ++++++
 rtl/csr_rmw_unit_if.sv | 42 ++++
 rtl/csr_rmw_alu.sv | 23 ++
 rtl/csr_rmw_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/csr_unit_pkg.sv
// Shared types for the Zicsr read-modify-write unit: FSM states, funct3
// encodings, CSR op kinds, the read-only address prefix and the decoder.
package csr_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } csr_state_t;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Write / set / clear; the reg-vs-imm flavour travels separately as use_imm.
  typedef enum logic [1:0] {
    OP_W = 2'b01,
    OP_S = 2'b10,
    OP_C = 2'b11
  } csr_op_t;

  // csr_addr[11:10] == 2'b11 marks the read-only CSR space.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef struct packed {
    csr_op_t op;
    logic    use_imm;
    logic    re;
    logic    we;
    logic    illegal;
  } csr_dec_t;

  // Decide which bus phases an instruction needs; funct3 000/100 are illegal.
  function automatic csr_dec_t csr_decode(input logic [2:0] f3,
                                          input logic [4:0] rs1_uimm,
                                          input logic [4:0] rd);
    csr_dec_t d;
    d.op      = OP_W;
    d.use_imm = f3[2];
    d.re      = 1'b0;
    d.we      = 1'b0;
    d.illegal = 1'b0;
    case (f3)
      F3_CSRRW, F3_CSRRWI: begin
        d.op = OP_W;
        d.we = 1'b1;
        d.re = (rd != 5'd0);
      end
      F3_CSRRS, F3_CSRRSI: begin
        d.op = OP_S;
        d.re = 1'b1;
        d.we = (rs1_uimm != 5'd0);
      end
      F3_CSRRC, F3_CSRRCI: begin
        d.op = OP_C;
        d.re = 1'b1;
        d.we = (rs1_uimm != 5'd0);
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/csr_rmw_unit_if.sv
// Bundle of the request handshake, CSR bus and response handshake.
// slave = the CSR unit itself, master = core/CSR-file environment around it.
interface csr_rmw_unit_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [4:0]      rs1_uimm;
  logic [4:0]      rd;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_data;
  logic [1:0]      priv;
  logic [11:0]     csr_addr_o;
  logic            csr_rd_req;
  logic            csr_rd_ack;
  logic [XLEN-1:0] csr_rd_data;
  logic            csr_wr_req;
  logic [XLEN-1:0] csr_wr_data;
  logic            csr_wr_ack;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rd_data;
  logic            rsp_rd_we;
  logic            rsp_illegal;

  modport slave (
    input  req_valid, funct3, rs1_uimm, rd, csr_addr, rs1_data, priv,
    output req_ready,
    output csr_addr_o, csr_rd_req, csr_wr_req, csr_wr_data,
    input  csr_rd_ack, csr_rd_data, csr_wr_ack,
    output rsp_valid, rsp_rd_data, rsp_rd_we, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, funct3, rs1_uimm, rd, csr_addr, rs1_data, priv,
    input  req_ready,
    input  csr_addr_o, csr_rd_req, csr_wr_req, csr_wr_data,
    output csr_rd_ack, csr_rd_data, csr_wr_ack,
    input  rsp_valid, rsp_rd_data, rsp_rd_we, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/csr_rmw_alu.sv
// Combinational new-value computation for CSRRW/S/C at XLEN bits.
module csr_rmw_alu
  import csr_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_t         op,
  input  logic [XLEN-1:0] operand,
  input  logic [XLEN-1:0] old_val,
  output logic [XLEN-1:0] new_val
);

  // Write replaces, set ORs in, clear masks out.
  always_comb begin
    new_val = operand;
    case (op)
      OP_S:    new_val = old_val | operand;
      OP_C:    new_val = old_val & ~operand;
      default: new_val = operand;
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// Multi-cycle Zicsr read-modify-write unit between execute and the CSR file.
// Optional build macro CSR_ACCESS_CHECK_EN: reject writes to read-only CSR
// space and accesses above the current privilege at acceptance time.
module csr_rmw_unit
  import csr_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           resetn,
  csr_rmw_unit_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  csr_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  csr_op_t         op_q, op_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            re_q, re_d, we_q, we_d, rd_nz_q, rd_nz_d;
  logic [11:0]     csr_addr_o_q, csr_addr_o_d;
  logic            csr_rd_req_q, csr_rd_req_d, csr_wr_req_q, csr_wr_req_d;
  logic [XLEN-1:0] csr_wr_data_q, csr_wr_data_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_rd_we_q, rsp_rd_we_d;
  logic            rsp_illegal_q, rsp_illegal_d;
  logic [XLEN-1:0] rsp_rd_data_q, rsp_rd_data_d;

  csr_dec_t        dec;
  logic            accept, acc_illegal, timeout_hit, abort;
  logic [XLEN-1:0] dec_operand, alu_operand, alu_new;
  csr_op_t         alu_op;

  assign dec         = csr_decode(bus.funct3, bus.rs1_uimm, bus.rd);
  assign accept      = bus.req_valid && (state_q == S_IDLE);
  assign dec_operand = dec.use_imm ? {{(XLEN-5){1'b0}}, bus.rs1_uimm} : bus.rs1_data;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

`ifdef CSR_ACCESS_CHECK_EN
  assign acc_illegal = (dec.we && (bus.csr_addr[11:10] == CSR_RO_PREFIX)) ||
                       (bus.priv < bus.csr_addr[9:8]);
`else
  logic [1:0] unused_priv;
  assign unused_priv = bus.priv;
  assign acc_illegal = 1'b0;
`endif

  // The ALU sees live decode while idle (write-only path) and latched fields
  // once a read is in flight; old value always comes straight off the bus.
  assign alu_op      = (state_q == S_IDLE) ? dec.op : op_q;
  assign alu_operand = (state_q == S_IDLE) ? dec_operand : operand_q;

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .op      (alu_op),
    .operand (alu_operand),
    .old_val (bus.csr_rd_data),
    .new_val (alu_new)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= OP_W;
      operand_q     <= '0;
      old_q         <= '0;
      re_q          <= 1'b0;
      we_q          <= 1'b0;
      rd_nz_q       <= 1'b0;
      csr_addr_o_q  <= '0;
      csr_rd_req_q  <= 1'b0;
      csr_wr_req_q  <= 1'b0;
      csr_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_rd_we_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      operand_q     <= operand_d;
      old_q         <= old_d;
      re_q          <= re_d;
      we_q          <= we_d;
      rd_nz_q       <= rd_nz_d;
      csr_addr_o_q  <= csr_addr_o_d;
      csr_rd_req_q  <= csr_rd_req_d;
      csr_wr_req_q  <= csr_wr_req_d;
      csr_wr_data_q <= csr_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_rd_we_q   <= rsp_rd_we_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // Next state and bus-wait counter; an ack in the expiry cycle beats timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d = '0;
        if (dec.illegal || acc_illegal) state_d = S_RESP;
        else if (dec.re)                state_d = S_READ;
        else                            state_d = S_WRITE;
      end
      S_READ: begin
        if (bus.csr_rd_ack) begin
          cnt_d   = '0;
          state_d = we_q ? S_WRITE : S_RESP;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          abort   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WRITE: begin
        if (bus.csr_wr_ack) state_d = S_RESP;
        else if (timeout_hit) begin
          state_d = S_RESP;
          abort   = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: if (bus.rsp_ready) state_d = S_IDLE;
    endcase
  end

  // Registered outputs and captured operands, loaded on each transition.
  always_comb begin
    op_d          = op_q;
    operand_d     = operand_q;
    old_d         = old_q;
    re_d          = re_q;
    we_d          = we_q;
    rd_nz_d       = rd_nz_q;
    csr_addr_o_d  = csr_addr_o_q;
    csr_wr_data_d = csr_wr_data_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_rd_we_d   = rsp_rd_we_q;
    rsp_illegal_d = rsp_illegal_q;
    csr_rd_req_d  = (state_d == S_READ);
    csr_wr_req_d  = (state_d == S_WRITE);
    rsp_valid_d   = (state_d == S_RESP);
    if (abort) begin
      rsp_rd_data_d = '0;
      rsp_rd_we_d   = 1'b0;
      rsp_illegal_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_d          = dec.op;
          operand_d     = dec_operand;
          re_d          = dec.re;
          we_d          = dec.we;
          rd_nz_d       = (bus.rd != 5'd0);
          csr_addr_o_d  = bus.csr_addr;
          old_d         = '0;
          rsp_rd_data_d = '0;
          rsp_rd_we_d   = 1'b0;
          rsp_illegal_d = (state_d == S_RESP);
          if (state_d == S_WRITE) csr_wr_data_d = alu_new;
        end
        S_READ: if (bus.csr_rd_ack) begin
          old_d = bus.csr_rd_data;
          if (we_q) csr_wr_data_d = alu_new;
          else begin
            rsp_rd_data_d = bus.csr_rd_data;
            rsp_rd_we_d   = rd_nz_q;
            rsp_illegal_d = 1'b0;
          end
        end
        S_WRITE: if (bus.csr_wr_ack) begin
          rsp_rd_data_d = re_q ? old_q : '0;
          rsp_rd_we_d   = re_q && rd_nz_q;
          rsp_illegal_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.csr_addr_o  = csr_addr_o_q;
  assign bus.csr_rd_req  = csr_rd_req_q;
  assign bus.csr_wr_req  = csr_wr_req_q;
  assign bus.csr_wr_data = csr_wr_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd_data = rsp_rd_data_q;
  assign bus.rsp_rd_we   = rsp_rd_we_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule
